border_box_overlay: RTL
=======================

Name: border_box_overlay

Overview:
- Reader side of the projection border RAMs: after each projection pass, fetches the column and row border tables and latches them into shadow registers.
- On the following frames, draws rectangular boxes around each detected digit region into the video stream (1-pixel outline, BOX_COLOR).
- Sits between the projection stage and the display/recognition output path; pixel stream passes through with fixed latency.

Parameters:
- NUM_ROW, 1, max digit rows held (row table depth 2*NUM_ROW)
- NUM_COL, 4, max digit columns held (column table depth 2*NUM_COL)
- H_PIXEL, 1280, active width; used for clamping
- V_PIXEL, 800, active height; used for clamping
- DEPBIT, 12, border RAM address/data width
- BOX_COLOR, 24'hFF0000, RGB888 outline color

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  async reset, active low
- project_done_flag  in  1  projection pass finished; tables stable while high
- num_col  in  4  columns found by projection
- num_row  in  4  rows found by projection
- frame_vsync  in  1  input vsync
- frame_hsync  in  1  input hsync
- frame_de  in  1  input data enable
- pixel_data  in  24  input RGB888
- xpos  in  11  current pixel x
- ypos  in  11  current pixel y
- col_border_addr_rd  out  DEPBIT  column table read address
- col_border_data_rd  in  DEPBIT  column table read data
- row_border_addr_rd  out  DEPBIT  row table read address
- row_border_data_rd  in  DEPBIT  row table read data
- out_vsync, out_hsync, out_de  out  1 each  sync signals delayed by 2 clk
- out_data  out  24  pixel with boxes drawn
- boxes_valid  out  1  shadow table holds a valid set

Behaviour:
- Table layout, fixed: entry k=0..N-1 uses address 2k+1 for left/top and 2k+2 for right/bottom. Address 0 is never read.
- Read contract: data_rd is valid 1 clk after addr_rd. Both tables are read in parallel.
- Reset: all outputs 0, addr_rd=0, boxes_valid=0, shadow and working registers 0, state IDLE.
- FSM states:
  - IDLE -> LOAD on rising edge of project_done_flag. Latch n_c=min(num_col,NUM_COL) and n_r=min(num_row,NUM_ROW).
  - LOAD: address i = 1..2*max(NUM_COL,NUM_ROW), one per clk. Capture each word into working registers on the following clk. Column addresses beyond 2*NUM_COL and row addresses beyond 2*NUM_ROW are held at the last valid address and ignored. Load lasts 2*max+1 clk, then -> WAIT.
  - WAIT -> IDLE on frame_vsync falling edge. At that moment copy the working set and n_c/n_r into the shadow set and set boxes_valid=1.
- Shadow set changes only at a vsync falling edge, so no tearing within a frame.
- A new project_done rise during LOAD is ignored. A rise during WAIT restarts LOAD; the working set is discarded.
- Box membership for column c<n_c and row r<n_r, with L,R,T,B from the shadow set:
  - Inside when L<=x<=R and T<=y<=B.
  - On the outline when inside and (x==L or x==R or y==T or y==B).
- Only columns c<n_c and rows r<n_r are drawn. n_c=0 or n_r=0 draws nothing. Boxes with L>R or T>B are skipped.
- Pipeline:
  - Stage 1 registers per-column x-hit/x-edge and per-row y-hit/y-edge compares.
  - Stage 2 ORs them and muxes the pixel.
  - Output = BOX_COLOR on the outline when out_de=1, else the delayed pixel_data. out_data=0 when out_de=0.
- Latency exactly 2 clk for data and all syncs.
- Compare widths: 11-bit unsigned. Border values are truncated to 11 bits.

Optional Feature:
- Macro: BORDER_CLAMP_EN.
- Defined: on shadow copy, left/top values >= H_PIXEL/V_PIXEL become 0 (underflow of the -2 margin wraps to large values). Right/bottom values >= H_PIXEL/V_PIXEL become H_PIXEL-1/V_PIXEL-1.
- Undefined: raw values are used; a wrapped left/top yields L>R and the box is skipped.

Test Plan:
- Reset mid-LOAD: assert rst_n=0 at the 3rd read -> all outputs 0, boxes_valid=0, no box drawn next frame.
- Single box: tables col{1:100,2:140}, row{1:50,2:200}, num_col=1, num_row=1. Pulse done, then vsync fall.
  - Next frame pixel (100,120) -> BOX_COLOR, 2 clk after input.
  - Pixel (120,120) -> input passthrough.
  - Pixel (140,50) -> BOX_COLOR.
- Four columns: num_col=4 with boxes at x 10-30, 60-80, 110-130, 160-180 and row 5-25.
  - Exactly 4 outlines appear.
  - num_col=7 -> clamped to 4; addresses stop at 8.
- Tear-free: change tables and pulse done mid-frame -> current frame unchanged; new boxes appear only after the next vsync fall.
- Wrapped left: col{1:0x7FE,2:20}.
  - Without BORDER_CLAMP_EN -> no box.
  - With it -> box drawn from x=0 to 20.
- Latency/syncs: random de/hsync pattern with n_c=0 -> out_* equal inputs delayed exactly 2 clk; out_data=0 whenever out_de=0.

Source files
------------

// File: rtl/border_box_overlay.sv
// Loads projection border tables into a shadow set and draws 1-pixel box outlines into the video stream.
// Optional BORDER_CLAMP_EN: clamp shadow borders into the active H_PIXEL x V_PIXEL area.
module border_box_overlay #(
  parameter int          NUM_ROW   = 1,
  parameter int          NUM_COL   = 4,
  parameter int          H_PIXEL   = 1280,
  parameter int          V_PIXEL   = 800,
  parameter int          DEPBIT    = 12,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              project_done_flag,
  input  logic [3:0]        num_col,
  input  logic [3:0]        num_row,
  input  logic              frame_vsync,
  input  logic              frame_hsync,
  input  logic              frame_de,
  input  logic [23:0]       pixel_data,
  input  logic [10:0]       xpos,
  input  logic [10:0]       ypos,
  output logic [DEPBIT-1:0] col_border_addr_rd,
  input  logic [DEPBIT-1:0] col_border_data_rd,
  output logic [DEPBIT-1:0] row_border_addr_rd,
  input  logic [DEPBIT-1:0] row_border_data_rd,
  output logic              out_vsync,
  output logic              out_hsync,
  output logic              out_de,
  output logic [23:0]       out_data,
  output logic              boxes_valid
);

  localparam int MAXN     = (NUM_COL > NUM_ROW) ? NUM_COL : NUM_ROW;
  localparam int LOAD_LEN = 2 * MAXN + 1;
  localparam int CNT_W    = $clog2(LOAD_LEN + 1);
  localparam logic [DEPBIT-1:0] COL_LAST = DEPBIT'(2 * NUM_COL);
  localparam logic [DEPBIT-1:0] ROW_LAST = DEPBIT'(2 * NUM_ROW);
  localparam logic [3:0]  NC_MAX = 4'(NUM_COL);
  localparam logic [3:0]  NR_MAX = 4'(NUM_ROW);
  localparam logic [10:0] H_LIM  = 11'(H_PIXEL);
  localparam logic [10:0] V_LIM  = 11'(V_PIXEL);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  function automatic logic [3:0] sat_cnt(input logic [3:0] n, input logic [3:0] lim);
    return (n > lim) ? lim : n;
  endfunction

`ifdef BORDER_CLAMP_EN
  function automatic logic [10:0] clamp_lo(input logic [10:0] v, input logic [10:0] lim);
    return (v >= lim) ? 11'd0 : v;
  endfunction

  function automatic logic [10:0] clamp_hi(input logic [10:0] v, input logic [10:0] lim);
    return (v >= lim) ? (lim - 11'd1) : v;
  endfunction
`endif

  state_t            state;
  logic              done_d;
  logic [CNT_W-1:0]  cnt;
  logic [DEPBIT-1:0] col_addr, row_addr;
  logic [3:0]        n_c, n_r, sh_nc, sh_nr;
  logic [10:0]       wcol [2*NUM_COL];
  logic [10:0]       wrow [2*NUM_ROW];
  logic [10:0]       sh_l [NUM_COL];
  logic [10:0]       sh_r [NUM_COL];
  logic [10:0]       sh_t [NUM_ROW];
  logic [10:0]       sh_b [NUM_ROW];

  logic              vsync_p1, hsync_p1, vld_p1;
  logic [23:0]       pix_p1;
  logic [NUM_COL-1:0] xin_p1, xedge_p1;
  logic [NUM_ROW-1:0] yin_p1, yedge_p1;
  logic              hit_p1;

  logic done_rise, vsync_fall;
  logic unused_ok;

  assign done_rise          = project_done_flag & ~done_d;
  assign vsync_fall         = vsync_p1 & ~frame_vsync;
  assign col_border_addr_rd = col_addr;
  assign row_border_addr_rd = row_addr;
  assign unused_ok = ^{col_border_data_rd, row_border_data_rd, H_LIM, V_LIM};

  // Table loader: rise of done starts a sweep, shadow copy waits for vsync fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      done_d      <= 1'b0;
      cnt         <= '0;
      col_addr    <= '0;
      row_addr    <= '0;
      n_c         <= '0;
      n_r         <= '0;
      sh_nc       <= '0;
      sh_nr       <= '0;
      boxes_valid <= 1'b0;
      for (int k = 0; k < 2*NUM_COL; k++) wcol[k] <= '0;
      for (int k = 0; k < 2*NUM_ROW; k++) wrow[k] <= '0;
      for (int c = 0; c < NUM_COL; c++) begin
        sh_l[c] <= '0;
        sh_r[c] <= '0;
      end
      for (int r = 0; r < NUM_ROW; r++) begin
        sh_t[r] <= '0;
        sh_b[r] <= '0;
      end
    end else begin
      done_d <= project_done_flag;
      if (done_rise && state != LOAD) begin
        state    <= LOAD;
        cnt      <= CNT_W'(1);
        col_addr <= DEPBIT'(1);
        row_addr <= DEPBIT'(1);
        n_c      <= sat_cnt(num_col, NC_MAX);
        n_r      <= sat_cnt(num_row, NR_MAX);
      end else begin
        case (state)
          LOAD: begin
            // read data lags the address by one clock, so word k lands at cnt == k+2
            for (int k = 0; k < 2*NUM_COL; k++)
              if (cnt == CNT_W'(k + 2)) wcol[k] <= 11'(col_border_data_rd);
            for (int k = 0; k < 2*NUM_ROW; k++)
              if (cnt == CNT_W'(k + 2)) wrow[k] <= 11'(row_border_data_rd);
            if (cnt < CNT_W'(2 * MAXN)) begin
              if (col_addr < COL_LAST) col_addr <= col_addr + DEPBIT'(1);
              if (row_addr < ROW_LAST) row_addr <= row_addr + DEPBIT'(1);
            end
            if (cnt == CNT_W'(LOAD_LEN)) state <= WAIT;
            cnt <= cnt + CNT_W'(1);
          end
          WAIT: begin
            if (vsync_fall) begin
              for (int c = 0; c < NUM_COL; c++) begin
`ifdef BORDER_CLAMP_EN
                sh_l[c] <= clamp_lo(wcol[2*c], H_LIM);
                sh_r[c] <= clamp_hi(wcol[2*c+1], H_LIM);
`else
                sh_l[c] <= wcol[2*c];
                sh_r[c] <= wcol[2*c+1];
`endif
              end
              for (int r = 0; r < NUM_ROW; r++) begin
`ifdef BORDER_CLAMP_EN
                sh_t[r] <= clamp_lo(wrow[2*r], V_LIM);
                sh_b[r] <= clamp_hi(wrow[2*r+1], V_LIM);
`else
                sh_t[r] <= wrow[2*r];
                sh_b[r] <= wrow[2*r+1];
`endif
              end
              sh_nc       <= n_c;
              sh_nr       <= n_r;
              boxes_valid <= 1'b1;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Stage 1: per-column and per-row range / edge compares
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p1 <= 1'b0;
      hsync_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      pix_p1   <= '0;
      xin_p1   <= '0;
      xedge_p1 <= '0;
      yin_p1   <= '0;
      yedge_p1 <= '0;
    end else begin
      vsync_p1 <= frame_vsync;
      hsync_p1 <= frame_hsync;
      vld_p1   <= frame_de;
      pix_p1   <= pixel_data;
      for (int c = 0; c < NUM_COL; c++) begin
        xin_p1[c]   <= boxes_valid && (4'(c) < sh_nc) && (sh_l[c] <= xpos) && (xpos <= sh_r[c]);
        xedge_p1[c] <= (xpos == sh_l[c]) || (xpos == sh_r[c]);
      end
      for (int r = 0; r < NUM_ROW; r++) begin
        yin_p1[r]   <= boxes_valid && (4'(r) < sh_nr) && (sh_t[r] <= ypos) && (ypos <= sh_b[r]);
        yedge_p1[r] <= (ypos == sh_t[r]) || (ypos == sh_b[r]);
      end
    end
  end

  always_comb begin
    hit_p1 = 1'b0;
    for (int c = 0; c < NUM_COL; c++)
      for (int r = 0; r < NUM_ROW; r++)
        if (xin_p1[c] && yin_p1[r] && (xedge_p1[c] || yedge_p1[r])) hit_p1 = 1'b1;
  end

  // Stage 2: outline mux and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vsync <= 1'b0;
      out_hsync <= 1'b0;
      out_de    <= 1'b0;
      out_data  <= '0;
    end else begin
      out_vsync <= vsync_p1;
      out_hsync <= hsync_p1;
      out_de    <= vld_p1;
      out_data  <= vld_p1 ? (hit_p1 ? BOX_COLOR : pix_p1) : 24'h0;
    end
  end

endmodule
